// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the 3-to-8 hold decoder: FSM state encoding and
// active-low seven-segment patterns (bit 0 = segment a ... bit 6 = segment g).
// -----------------------------------------------------------------------------
package decode_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage : decode_pkg

// File: rtl/hex7seg_lut.sv
// -----------------------------------------------------------------------------
// hex7seg_lut
// Purely combinational map from a 3-bit index to an active-low digit pattern.
// The parent registers the result.
//   i_code [2:0] : index 0-7
//   o_seg  [6:0] : active-low segments, o_seg[0] = a ... o_seg[6] = g
// -----------------------------------------------------------------------------
module hex7seg_lut
  import decode_pkg::*;
(
  input  logic [2:0] i_code,
  output logic [6:0] o_seg
);

  // Index to segment pattern lookup.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      3'd0:    o_seg = SEG_0;
      3'd1:    o_seg = SEG_1;
      3'd2:    o_seg = SEG_2;
      3'd3:    o_seg = SEG_3;
      3'd4:    o_seg = SEG_4;
      3'd5:    o_seg = SEG_5;
      3'd6:    o_seg = SEG_6;
      3'd7:    o_seg = SEG_7;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule : hex7seg_lut

// File: rtl/decode38_hold.sv
// -----------------------------------------------------------------------------
// decode38_hold
// Sequential 3-to-8 decoder. Codes arrive on a valid/ready handshake, each is
// shown one-hot on y (and as a digit on seg) for HOLD_CYCLES cycles. A one-deep
// pending buffer catches a code arriving while another is on display, so a
// continuous stream is shown back-to-back with no blank cycles.
//   clk         : system clock, rising edge
//   rstn        : synchronous active-low reset
//   en          : block enable, low = synchronous flush
//   code [2:0]  : encoded index
//   code_vld    : code is valid
//   code_rdy    : block can accept code (combinational)
//   y    [7:0]  : registered one-hot pattern, zero when idle
//   seg  [6:0]  : registered active-low digit, blank when idle
//   sig         : registered, high while a pattern is shown
// -----------------------------------------------------------------------------
module decode38_hold
  import decode_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [2:0] code,
  input  logic       code_vld,
  output logic       code_rdy,
  output logic [7:0] y,
  output logic [6:0] seg,
  output logic       sig
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cur;
  logic [2:0]    w_cur_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_pend;
  logic [2:0]    w_pend_nxt;
  logic          r_pend_vld;
  logic          w_pend_vld_nxt;

  logic          w_accept;
  logic [6:0]    w_lut_seg;
  logic [7:0]    w_y_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_sig_nxt;
  logic [7:0]    r_y;
  logic [6:0]    r_seg;
  logic          r_sig;

  // Ready drops while reset is held so nothing is taken during reset.
  assign code_rdy = rstn && en && !r_pend_vld;
  assign w_accept = code_vld && code_rdy;

  hex7seg_lut u_lut (
    .i_code (r_cur),
    .o_seg  (w_lut_seg)
  );

  // State register with counter and pending buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cur      <= 3'd0;
      r_cnt      <= CNT_ZERO;
      r_pend     <= 3'd0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

  // Next-state logic: hold countdown, pending capture and back-to-back reload.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_cnt_nxt      = r_cnt;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    if (!en) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = CNT_ZERO;
      w_pend_vld_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_nxt = SHOW;
            w_cur_nxt   = code;
            w_cnt_nxt   = CNT_RELOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        SHOW: begin
          if (r_cnt != CNT_ZERO) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (w_accept) begin
              w_pend_nxt     = code;
              w_pend_vld_nxt = 1'b1;
            end else begin
              w_pend_vld_nxt = r_pend_vld;
            end
          end else if (r_pend_vld) begin
            // Pending code takes priority; ready is low here so no accept.
            w_cur_nxt      = r_pend;
            w_cnt_nxt      = CNT_RELOAD;
            w_pend_vld_nxt = 1'b0;
          end else if (w_accept) begin
            w_cur_nxt = code;
            w_cnt_nxt = CNT_RELOAD;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_cnt_nxt      = CNT_ZERO;
          w_pend_vld_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the current state; registered below.
  always_comb begin
    w_y_nxt   = 8'd0;
    w_seg_nxt = SEG_BLANK;
    w_sig_nxt = 1'b0;
    if (r_state == SHOW) begin
      w_y_nxt   = 8'd1 << r_cur;
      w_seg_nxt = w_lut_seg;
      w_sig_nxt = 1'b1;
    end else begin
      w_y_nxt   = 8'd0;
      w_seg_nxt = SEG_BLANK;
      w_sig_nxt = 1'b0;
    end
  end

  // Output registers; reset and flush blank the display on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_y   <= 8'd0;
      r_seg <= SEG_BLANK;
      r_sig <= 1'b0;
    end else if (!en) begin
      r_y   <= 8'd0;
      r_seg <= SEG_BLANK;
      r_sig <= 1'b0;
    end else begin
      r_y   <= w_y_nxt;
      r_seg <= w_seg_nxt;
      r_sig <= w_sig_nxt;
    end
  end

  assign y   = r_y;
  assign seg = r_seg;
  assign sig = r_sig;

endmodule : decode38_hold

// File: tb/tb_decode38_hold.sv
// -----------------------------------------------------------------------------
// tb_decode38_hold
// Directed bench for decode38_hold: one instance with HOLD_CYCLES=4 and one
// with HOLD_CYCLES=1, sharing clock, reset and enable.
// -----------------------------------------------------------------------------
module tb_decode38_hold;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [2:0] code;
  logic       code_vld;
  logic       code_rdy;
  logic [7:0] y;
  logic [6:0] seg;
  logic       sig;

  logic [2:0] code1;
  logic       vld1;
  logic       rdy1;
  logic [7:0] y1;
  logic [6:0] seg1;
  logic       sig1;

  int n_checks;
  int n_pass;

  decode38_hold #(.HOLD_CYCLES(4)) dut4 (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .code     (code),
    .code_vld (code_vld),
    .code_rdy (code_rdy),
    .y        (y),
    .seg      (seg),
    .sig      (sig)
  );

  decode38_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .code     (code1),
    .code_vld (vld1),
    .code_rdy (rdy1),
    .y        (y1),
    .seg      (seg1),
    .sig      (sig1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; code = 3'd5; code_vld = 1'b1; code1 = 3'd1; vld1 = 1'b1;
    tick(); tick();
    n_checks++; if (y !== 8'h00) $display("FAIL reset_y got %h want 00", y); else n_pass++;
    n_checks++; if (seg !== 7'b1111111) $display("FAIL reset_seg got %b want 1111111", seg); else n_pass++;
    n_checks++; if (sig !== 1'b0) $display("FAIL reset_sig got %b want 0", sig); else n_pass++;
    n_checks++; if (code_rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", code_rdy); else n_pass++;
    n_checks++; if (y1 !== 8'h00) $display("FAIL reset_y1 got %h want 00", y1); else n_pass++;
    n_checks++; if (rdy1 !== 1'b0) $display("FAIL reset_rdy1 got %b want 0", rdy1); else n_pass++;
    code_vld = 1'b0; vld1 = 1'b0; rstn = 1'b1;
    #1;
    n_checks++; if (code_rdy !== 1'b1) $display("FAIL release_rdy got %b want 1", code_rdy); else n_pass++;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL release_rdy1 got %b want 1", rdy1); else n_pass++;
    tick();
  endtask

  task automatic test_single();
    code = 3'd5; code_vld = 1'b1;
    tick();
    code_vld = 1'b0;
    n_checks++; if (y !== 8'h00) $display("FAIL single_latency got %h want 00", y); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (y !== 8'b0010_0000) $display("FAIL single_y c%0d got %h want 20", i, y); else n_pass++;
      n_checks++; if (seg !== 7'b0010010) $display("FAIL single_seg c%0d got %b want 0010010", i, seg); else n_pass++;
      n_checks++; if (sig !== 1'b1) $display("FAIL single_sig c%0d got %b want 1", i, sig); else n_pass++;
    end
    tick();
    n_checks++; if (y !== 8'h00) $display("FAIL single_end_y got %h want 00", y); else n_pass++;
    n_checks++; if (seg !== 7'b1111111) $display("FAIL single_end_seg got %b want 1111111", seg); else n_pass++;
    n_checks++; if (sig !== 1'b0) $display("FAIL single_end_sig got %b want 0", sig); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_y;
    logic       exp_rdy;
    code = 3'd3; code_vld = 1'b1;
    tick();
    code = 3'd6;
    n_checks++; if (code_rdy !== 1'b1) $display("FAIL b2b_rdy_pre got %b want 1", code_rdy); else n_pass++;
    tick();
    code_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_y   = (k < 4) ? 8'h08 : 8'h40;
      exp_rdy = (k >= 3) ? 1'b1 : 1'b0;
      n_checks++; if (y !== exp_y) $display("FAIL b2b_y c%0d got %h want %h", k, y, exp_y); else n_pass++;
      n_checks++; if (code_rdy !== exp_rdy) $display("FAIL b2b_rdy c%0d got %b want %b", k, code_rdy, exp_rdy); else n_pass++;
      tick();
    end
    n_checks++; if (y !== 8'h00) $display("FAIL b2b_end_y got %h want 00", y); else n_pass++;
  endtask

  task automatic test_stream();
    int         idx;
    int         k;
    bit         started;
    bit         tail_done;
    bit         acc;
    logic [7:0] exp_y;
    idx = 0; k = 0; started = 1'b0; tail_done = 1'b0;
    code = 3'd0; code_vld = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = code_vld && code_rdy;
      tick();
      if (acc) begin
        idx++;
        if (idx < 8) code = 3'(idx);
        else code_vld = 1'b0;
      end
      if (!started && y !== 8'h00) started = 1'b1;
      if (started && k < 32) begin
        exp_y = 8'd1 << (k / 4);
        n_checks++; if (y !== exp_y) $display("FAIL stream_y k%0d got %h want %h", k, y, exp_y); else n_pass++;
        k++;
      end else if (started && !tail_done) begin
        tail_done = 1'b1;
        n_checks++; if (y !== 8'h00) $display("FAIL stream_tail got %h want 00", y); else n_pass++;
      end
    end
    n_checks++; if (k != 32) $display("FAIL stream_count got %0d want 32", k); else n_pass++;
    code_vld = 1'b0;
  endtask

  task automatic test_en_flush();
    code = 3'd2; code_vld = 1'b1;
    tick();
    code = 3'd4;
    tick();
    code_vld = 1'b0;
    n_checks++; if (code_rdy !== 1'b0) $display("FAIL flush_pend_rdy got %b want 0", code_rdy); else n_pass++;
    n_checks++; if (y !== 8'h04) $display("FAIL flush_y1 got %h want 04", y); else n_pass++;
    tick();
    n_checks++; if (y !== 8'h04) $display("FAIL flush_y2 got %h want 04", y); else n_pass++;
    en = 1'b0;
    tick();
    n_checks++; if (y !== 8'h00) $display("FAIL flush_y got %h want 00", y); else n_pass++;
    n_checks++; if (sig !== 1'b0) $display("FAIL flush_sig got %b want 0", sig); else n_pass++;
    n_checks++; if (seg !== 7'b1111111) $display("FAIL flush_seg got %b want 1111111", seg); else n_pass++;
    n_checks++; if (code_rdy !== 1'b0) $display("FAIL flush_rdy_en0 got %b want 0", code_rdy); else n_pass++;
    en = 1'b1;
    #1;
    n_checks++; if (code_rdy !== 1'b1) $display("FAIL flush_rdy_en1 got %b want 1", code_rdy); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (y !== 8'h00) $display("FAIL flush_pend_lost c%0d got %h want 00", i, y); else n_pass++;
    end
    code = 3'd7; code_vld = 1'b1;
    tick();
    code_vld = 1'b0;
    tick();
    n_checks++; if (seg !== 7'b1111000) $display("FAIL flush_seg7 got %b want 1111000", seg); else n_pass++;
    n_checks++; if (y !== 8'h80) $display("FAIL flush_y7 got %h want 80", y); else n_pass++;
    n_checks++; if (sig !== 1'b1) $display("FAIL flush_sig7 got %b want 1", sig); else n_pass++;
    repeat (5) tick();
  endtask

  task automatic test_reset_midhold();
    code = 3'd1; code_vld = 1'b1;
    tick();
    code_vld = 1'b0;
    tick();
    n_checks++; if (y !== 8'h02) $display("FAIL midrst_pre got %h want 02", y); else n_pass++;
    rstn = 1'b0;
    tick();
    n_checks++; if (y !== 8'h00) $display("FAIL midrst_y got %h want 00", y); else n_pass++;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (y !== 8'h00) $display("FAIL midrst_after c%0d got %h want 00", i, y); else n_pass++;
    end
  endtask

  task automatic test_hold1();
    code1 = 3'd1; vld1 = 1'b1;
    tick();
    code1 = 3'd2;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL h1_rdy got %b want 1", rdy1); else n_pass++;
    tick();
    n_checks++; if (y1 !== 8'h02) $display("FAIL h1_y_a got %h want 02", y1); else n_pass++;
    code1 = 3'd4;
    tick();
    n_checks++; if (y1 !== 8'h04) $display("FAIL h1_y_b got %h want 04", y1); else n_pass++;
    vld1 = 1'b0;
    tick();
    n_checks++; if (y1 !== 8'h10) $display("FAIL h1_y_c got %h want 10", y1); else n_pass++;
    n_checks++; if (seg1 !== 7'b0011001) $display("FAIL h1_seg_c got %b want 0011001", seg1); else n_pass++;
    tick();
    n_checks++; if (y1 !== 8'h00) $display("FAIL h1_end got %h want 00", y1); else n_pass++;
    n_checks++; if (sig1 !== 1'b0) $display("FAIL h1_end_sig got %b want 0", sig1); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stream();
    test_en_flush();
    test_reset_midhold();
    test_hold1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_decode38_hold
